// File: rtl/svga_timing_pkg.sv
// Shared SVGA 800x600@56Hz timing defaults and derived totals, used by the
// timing generator parameter defaults and by downstream renderers.
package svga_timing_pkg;

  localparam int unsigned H_W  = 11;
  localparam int unsigned V_W  = 10;
  localparam int unsigned FC_W = 16;

  localparam int unsigned H_TOTAL_LIMIT = 1 << H_W;
  localparam int unsigned V_TOTAL_LIMIT = 1 << V_W;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 72;
  localparam int unsigned DEF_H_BP     = 128;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 22;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Video control bits that travel together through the optional delay stage.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_en;
  } sync_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with enable; exposes its next value so callers can
// register decodes that line up with the counter itself.
module wrap_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = en && (count == MAX_V);

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = (count == MAX_V) ? '0 : count + WIDTH'(1);
    end
  end

  // Resetting to MAX makes the first enabled edge after reset land on 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= MAX_V;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator: pixel/line counters plus registered sync,
// blanking and frame markers. Define SVGA_SYNC_PIPE_EN to delay hsync/vsync/display_en by one cycle.
module svga_timing_gen
  import svga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic            pixel_clk,
  input  logic            rst,
  output logic [H_W-1:0]  h_coord,
  output logic [V_W-1:0]  v_coord,
  output logic            hsync,
  output logic            vsync,
  output logic            display_en,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, display_en: 1'b0};

  generate
    if ((H_TOTAL > H_TOTAL_LIMIT) || (V_TOTAL > V_TOTAL_LIMIT)) begin : g_bad_timing
      $error("svga_timing_gen: H_TOTAL or V_TOTAL exceeds the coordinate port width");
    end
  endgenerate

  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           h_wrap;
  logic           v_wrap;

  wrap_counter #(
    .WIDTH (H_W),
    .MAX   (H_TOTAL - 1)
  ) u_h_counter (
    .clk        (pixel_clk),
    .rst        (rst),
    .en         (1'b1),
    .count      (h_coord),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  wrap_counter #(
    .WIDTH (V_W),
    .MAX   (V_TOTAL - 1)
  ) u_v_counter (
    .clk        (pixel_clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (v_coord),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decode from the counters' next values so the registered flags share a cycle with h_coord/v_coord.
  sync_t sync_next;
  sync_t sync_reg;
  sync_t sync_out;

  always_comb begin
    sync_next            = SYNC_IDLE;
    sync_next.display_en = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
    sync_next.hsync      = ((32'(h_next) >= HS_START) && (32'(h_next) < HS_END)) ? HS_POL : ~HS_POL;
    sync_next.vsync      = ((32'(v_next) >= VS_START) && (32'(v_next) < VS_END)) ? VS_POL : ~VS_POL;
  end

  // v_wrap is exactly the step from the last pixel of the frame onto (0,0).
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_reg    <= SYNC_IDLE;
      frame_start <= 1'b0;
      frame_cnt   <= '1;
    end else begin
      sync_reg    <= sync_next;
      frame_start <= v_wrap;
      frame_cnt   <= frame_cnt + {{(FC_W-1){1'b0}}, v_wrap};
    end
  end

`ifdef SVGA_SYNC_PIPE_EN
  sync_t sync_dly;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_dly <= SYNC_IDLE;
    end else begin
      sync_dly <= sync_reg;
    end
  end

  assign sync_out = sync_dly;
`else
  assign sync_out = sync_reg;
`endif

  assign hsync      = sync_out.hsync;
  assign vsync      = sync_out.vsync;
  assign display_en = sync_out.display_en;

endmodule

// File: tb/tb_svga_timing_gen.sv
// Self-checking bench for svga_timing_gen using a reduced raster (28x12) so
// whole frames fit in a short run; honours SVGA_SYNC_PIPE_EN.
`timescale 1ns/1ps
module tb_svga_timing_gen;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;
`ifdef SVGA_SYNC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        hsync, vsync, display_en, frame_start;
  logic [15:0] frame_cnt;

  always #5 pixel_clk = ~pixel_clk;

  svga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (HP), .VS_POL (VP)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .h_coord     (h_coord),
    .v_coord     (v_coord),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_en  (display_en),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int t;
    int h;
    int v;
    bit de, hsa, vsa;
    bit de_p, hsa_p, vsa_p;
    bit fs;
    int fc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int t = -1;  // cycles since reset release; -1 while in reset

  // Raster position is a pure function of elapsed cycles since release.
  function automatic obs_t model(input int tt);
    obs_t o;
    int   ts, hh, vv;
    o = '{h: 11'(HT - 1), v: 10'(VT - 1), hs: ~HP, vs: ~VP, de: 1'b0, fs: 1'b0, fc: 16'hFFFF};
    if (tt >= 0) begin
      o.h  = 11'(tt % HT);
      o.v  = 10'((tt / HT) % VT);
      o.fs = ((tt % FR) == 0);
      o.fc = 16'(tt / FR);
      ts   = PIPE ? tt - 1 : tt;
      if (ts >= 0) begin
        hh   = ts % HT;
        vv   = (ts / HT) % VT;
        o.de = (hh < HA) && (vv < VA);
        o.hs = (hh >= HA + HF && hh < HA + HF + HS) ? HP : ~HP;
        o.vs = (vv >= VA + VF && vv < VA + VF + VS) ? VP : ~VP;
      end
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{h: h_coord, v: v_coord, hs: hsync, vs: vsync, de: display_en, fs: frame_start, fc: frame_cnt};
    return o;
  endfunction

  task automatic tick();
    @(posedge pixel_clk);
    if (rst) t = -1;
    else     t = t + 1;
    @(negedge pixel_clk);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d act h=%0d v=%0d hs=%b vs=%b de=%b fs=%b fc=%h exp h=%0d v=%0d hs=%b vs=%b de=%b fs=%b fc=%h",
               name, t, act.h, act.v, act.hs, act.vs, act.de, act.fs, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.fs, exp.fc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  vec_t tbl[19];

  initial begin
    obs_t e;
    int   n, vs_cnt, hs_cnt, hs_first, de_fall;
    bit   found;

    //        t    h   v  de hs vs  dp hp vp  fs fc
    tbl[0]  = '{0,   0,  0, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{15,  15, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{16,  16, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{17,  17, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{18,  18, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{19,  19, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{20,  20, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{22,  22, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{23,  23, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{24,  24, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{28,  0,  1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{168, 0,  6, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{196, 0,  7, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{197, 1,  7, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[14] = '{251, 27, 8, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[15] = '{252, 0,  9, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{253, 1,  9, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{335, 27, 11, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{336, 0,  0, 1, 0, 0, 0, 0, 0, 1, 1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset_hold", model(-1));

    // Table-driven walk through one frame after release
    rst = 1'b0;
    foreach (tbl[i]) begin
      while (t < tbl[i].t) tick();
      e.h  = 11'(tbl[i].h);
      e.v  = 10'(tbl[i].v);
      e.de = PIPE ? tbl[i].de_p : tbl[i].de;
      e.hs = (PIPE ? tbl[i].hsa_p : tbl[i].hsa) ? HP : ~HP;
      e.vs = (PIPE ? tbl[i].vsa_p : tbl[i].vsa) ? VP : ~VP;
      e.fs = tbl[i].fs;
      e.fc = 16'(tbl[i].fc);
      check($sformatf("table_t%0d", tbl[i].t), e);
    end

    // One line after a fresh release: hsync width/position and blanking edge
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    hs_cnt = 0; hs_first = -1; de_fall = -1;
    for (int i = 0; i < HT; i++) begin
      tick();
      if (hsync == HP) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(h_coord);
      end
      if (!display_en && de_fall < 0 && h_coord != 0) de_fall = int'(h_coord);
    end
    check_int("line_hsync_width", hs_cnt, HS);
    check_int("line_hsync_first_h", hs_first, HA + HF + int'(PIPE));
    check_int("line_de_fall_h", de_fall, HA + int'(PIPE));

    // One frame: spacing of frame_start pulses and vsync duration
    found = 1'b0;
    for (int i = 0; i < FR + 2 && !found; i++) begin
      tick();
      found = frame_start;
    end
    check_int("frame_start_seen", int'(found), 1);
    n = 0; vs_cnt = 0; found = 1'b0;
    while (!found && n < 2 * FR) begin
      tick();
      n++;
      if (vsync == VP) vs_cnt++;
      found = frame_start;
    end
    check_int("frame_period", n, FR);
    check_int("frame_vsync_cycles", vs_cnt, VS * HT);

    // Reset asserted mid-frame for three cycles
    found = 1'b0;
    for (int i = 0; i < FR + 2 && !found; i++) begin
      tick();
      found = (h_coord == 11'd10) && (v_coord == 10'd5);
    end
    check_int("midframe_reach", int'(found), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midframe_rst%0d", i), model(-1));
    end
    rst = 1'b0;
    tick();
    check("post_rst_first", model(0));
    check_int("post_rst_fc_wrap", int'(frame_cnt), 0);

    // Randomized run lengths and reset pulses against the cycle model
    for (int ep = 0; ep < 25; ep++) begin
      n = int'($urandom_range(30, 900));
      for (int i = 0; i < n; i++) begin
        tick();
        check("rand_run", model(t));
      end
      rst = 1'b1;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        tick();
        check("rand_rst", model(t));
      end
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/svga_timing_gen.md
SVGA_TIMING_GEN -- requirements
Module: svga_timing_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (parameters and ports below).
REQ-002 H_ACTIVE, default 800, SHALL be the visible pixels per line.
REQ-003 H_FP, default 24, SHALL be the horizontal front porch in pixels.
REQ-004 H_SYNC, default 72, SHALL be the horizontal sync width in pixels.
REQ-005 H_BP, default 128, SHALL be the horizontal back porch in pixels.
REQ-006 V_ACTIVE, default 600, SHALL be the visible lines per frame.
REQ-007 V_FP, default 1, SHALL be the vertical front porch in lines.
REQ-008 V_SYNC, default 2, SHALL be the vertical sync width in lines.
REQ-009 V_BP, default 22, SHALL be the vertical back porch in lines.
REQ-010 HS_POL, default 1, SHALL be the active level of hsync; VS_POL, default 1, SHALL be the active level of vsync.
REQ-011 pixel_clk  in  1  SHALL be the 36 MHz pixel clock; all logic is on its rising edge.
REQ-012 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-013 h_coord  out  11  SHALL be the horizontal pixel counter.
REQ-014 v_coord  out  10  SHALL be the vertical line counter.
REQ-015 hsync  out  1  SHALL be horizontal sync at HS_POL level.
REQ-016 vsync  out  1  SHALL be vertical sync at VS_POL level.
REQ-017 display_en  out  1  SHALL be high only in the visible region.
REQ-018 frame_start  out  1  SHALL be a one-cycle pulse at coordinate (0,0).
REQ-019 frame_cnt  out  16  SHALL be a free-running frame counter.

Function
REQ-020 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 1024); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 625), giving 800x600 at 56 Hz from 36 MHz.
REQ-021 h_coord SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-022 v_coord SHALL increment only on the h_coord wrap and wrap from V_TOTAL-1 to 0 when both counters are at their maximum.
REQ-023 display_en SHALL be 1 iff h_coord<H_ACTIVE and v_coord<V_ACTIVE.
REQ-024 hsync SHALL be active iff H_ACTIVE+H_FP <= h_coord < H_ACTIVE+H_FP+H_SYNC (default 824..895).
REQ-025 vsync SHALL be active iff V_ACTIVE+V_FP <= v_coord < V_ACTIVE+V_FP+V_SYNC (default 601..602), changing on the same cycle h_coord becomes 0.
REQ-026 All outputs SHALL be registered; hsync, vsync, display_en and frame_start SHALL be decoded from next-state counter values, so they align with h_coord/v_coord in the same cycle (zero relative latency).
REQ-027 frame_start SHALL be 1 exactly on the cycle h_coord=0 and v_coord=0, and 0 otherwise.
REQ-028 frame_cnt SHALL increment by 1 on the cycle frame_start asserts and wrap from 16'hFFFF to 0.
REQ-029 Counter arithmetic SHALL be unsigned at the port width; a parameter set with H_TOTAL>2048 or V_TOTAL>1024 SHALL fail elaboration.

Reset
REQ-030 While rst=1: h_coord=H_TOTAL-1, v_coord=V_TOTAL-1, display_en=0, hsync=!HS_POL, vsync=!VS_POL, frame_start=0, frame_cnt=16'hFFFF.
REQ-031 On the first rising edge with rst=0: h_coord=0, v_coord=0, display_en=1, frame_start=1, frame_cnt=0.
REQ-032 rst asserted mid-frame SHALL force the REQ-030 values on the next edge, with no partial line or sync pulse completed.

Configuration
REQ-033 With SVGA_SYNC_PIPE_EN defined, hsync, vsync and display_en SHALL be delayed by one extra register stage relative to h_coord/v_coord, matching one-cycle registered pixel-data consumers. This stage SHALL reset to the REQ-030 values.
REQ-034 Without SVGA_SYNC_PIPE_EN, the REQ-026 alignment SHALL hold; h_coord, v_coord, frame_start and frame_cnt SHALL be unaffected in both cases.

Structure
REQ-035 Default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in shared package svga_timing_pkg, used by the parameter defaults and by downstream renderers.
REQ-036 One sub-module, wrap_counter (parameterised width/max, enable, wrap flag), SHALL be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-037 Release reset -> the first cycle shows (0,0), display_en=1, frame_start=1, frame_cnt=0.
REQ-038 Run one line -> hsync high exactly for h_coord 824..895 (72 cycles); display_en falls at h_coord=800.
REQ-039 Run one frame -> 640000 cycles between frame_start pulses; vsync high for exactly 2048 cycles on lines 601..602.
REQ-040 Assert rst at (h=500,v=300) for 3 cycles -> outputs match REQ-030; the next frame_start follows release by 1 cycle.
REQ-041 Preload frame_cnt near wrap (65536 frames, or force) -> frame_cnt goes 16'hFFFF to 0 on frame_start.
REQ-042 Define SVGA_SYNC_PIPE_EN -> hsync rises at h_coord=825 and display_en falls at h_coord=801; coordinates are unchanged.
